// File: rtl/bch_encoder_arbiter.sv
// Codeword-granular round-robin arbiter sharing one bit-serial BCH encoder between NUM_CH
// source/destination FIFO pairs. Optional per-channel codeword counters: BCH_ARB_STATS_EN.
`timescale 1ns/1ps
module bch_encoder_arbiter #(
  parameter int NUM_CH = 2,
  parameter int N      = 7,
  parameter int K      = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         SRC_DATA,
  input  logic [NUM_CH-1:0]         SRC_EMPTY,
  output logic [NUM_CH-1:0]         SRC_RE,
  output logic                      ENC_IN_DATA,
  output logic                      ENC_IN_EMPTY,
  input  logic                      ENC_IN_RE,
  input  logic                      ENC_OUT_DATA,
  input  logic                      ENC_OUT_WE,
  output logic                      ENC_OUT_FULL,
  output logic                      DST_DATA,
  output logic [NUM_CH-1:0]         DST_WE,
  input  logic [NUM_CH-1:0]         DST_FULL,
  output logic [$clog2(NUM_CH)-1:0] GRANT,
  output logic                      BUSY
`ifdef BCH_ARB_STATS_EN
  ,
  output logic [16*NUM_CH-1:0]      CW_COUNT
`endif
);

  localparam int GW = $clog2(NUM_CH);
  localparam int RW = $clog2(K+1);
  localparam int WW = $clog2(N+1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic          r_busy;
  logic [RW-1:0] r_rd_cnt;
  logic [WW-1:0] r_wr_cnt;

  logic          w_any_src;
  logic [GW-1:0] w_pick;
  logic          w_in_empty;
  logic          w_rd_fire;
  logic          w_wr_fire;
  logic          w_last_wr;

  assign GRANT = r_grant;
  assign BUSY  = r_busy;

  // Round-robin pick: first non-empty source strictly after the last granted one.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    w_pick    = r_last_grant;
    w_any_src = ~&SRC_EMPTY;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = (int'(r_last_grant) + off) % NUM_CH;
      if (!found && !SRC_EMPTY[idx]) begin
        w_pick = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_in_empty = 1'b1;
    if (r_state == ST_LOCKED)
      w_in_empty = (r_rd_cnt == RW'(K)) | SRC_EMPTY[r_grant];
  end

  assign w_rd_fire = (r_state == ST_LOCKED) & ENC_IN_RE & ~w_in_empty;
  assign w_wr_fire = (r_state == ST_LOCKED) & ENC_OUT_WE & (r_wr_cnt != WW'(N));
  assign w_last_wr = w_wr_fire & (r_wr_cnt == WW'(N-1));

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_src) w_next_state = ST_LOCKED;
      ST_LOCKED: if (w_last_wr) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Encoder-facing side follows the granted pair only; everything else stays quiet.
  always_comb begin
    SRC_RE          = '0;
    DST_WE          = '0;
    SRC_RE[r_grant] = w_rd_fire;
    DST_WE[r_grant] = w_wr_fire;
    ENC_IN_EMPTY    = w_in_empty;
    ENC_IN_DATA     = SRC_DATA[r_grant];
    ENC_OUT_FULL    = (r_state == ST_LOCKED) ? DST_FULL[r_grant] : 1'b1;
    DST_DATA        = ENC_OUT_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_CH-1);
      r_busy       <= 1'b0;
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_any_src) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
        end
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_rd_fire) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_wr_fire) r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      r_busy <= (w_next_state == ST_LOCKED);
    end
  end

`ifdef BCH_ARB_STATS_EN
  logic [15:0] r_cw_cnt [NUM_CH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) r_cw_cnt[i] <= '0;
    end else if (w_last_wr && (r_cw_cnt[r_grant] != 16'hFFFF)) begin
      r_cw_cnt[r_grant] <= r_cw_cnt[r_grant] + 16'd1;
    end
  end

  always_comb begin
    CW_COUNT = '0;
    for (int i = 0; i < NUM_CH; i++) CW_COUNT[16*i +: 16] = r_cw_cnt[i];
  end
`endif

endmodule
